pio_in_edge_irq_gen2: RTL

Parametrised multi-bit Avalon-MM input PIO, the next generation of the single-bit push-button edge-capture PIO. Each channel has a synchroniser, a programmable debounce filter, per-bit rising/falling edge selection, a per-bit edge-capture register with write-1-to-clear, and a per-bit IRQ mask. It sits on the Qsys system bus between board buttons/switches and the Nios II interrupt controller.

---
 rtl/pio_gen2_pkg.sv | 20 ++
 rtl/pio_debounce_ch.sv | 56 +++++
 rtl/pio_in_edge_irq_gen2.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pio_gen2_pkg.sv
// Shared constants and helpers for the gen2 edge-capture input PIO.
package pio_gen2_pkg;

   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD  = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_RAW     = 3'd6;

   // All-ones mask over the low w bits, used as the default falling-edge enable.
   function automatic logic [31:0] fall_reset_default(input int unsigned w);
      if (w >= 32) return 32'hFFFF_FFFF;
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: two-flop synchroniser followed by a hold-for-P-cycles debounce filter.
module pio_debounce_ch #(
   parameter int unsigned DB_CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_raw,
   input  logic [DB_CNT_W-1:0] period,
   input  logic                cnt_clr,
   output logic                sync_o,
   output logic                stable_o
);

   logic                meta_q, meta_d;
   logic                sync_q, sync_d;
   logic                stable_q, stable_d;
   logic [DB_CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // A differing sync value must persist for `period` evaluations before it is accepted.
   always_comb begin
      meta_d   = in_raw;
      sync_d   = meta_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (period == '0) begin
         stable_d = sync_q;
         cnt_d    = '0;
      end else if (sync_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == (period - DB_CNT_W'(1))) begin
         stable_d = sync_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + DB_CNT_W'(1);
      end
      if (cnt_clr) cnt_d = '0;
   end

   assign sync_o   = sync_q;
   assign stable_o = stable_q;

endmodule

// File: rtl/pio_in_edge_irq_gen2.sv
// Multi-bit Avalon-MM input PIO with debounce, per-bit edge select, W1C edge capture and masked IRQ.
module pio_in_edge_irq_gen2
   import pio_gen2_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DB_CNT_W   = 16,
   parameter int unsigned DB_RESET   = 0,
   parameter logic [31:0] RISE_RESET = 32'h0,
   parameter logic [31:0] FALL_RESET = fall_reset_default(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   logic [WIDTH-1:0]    sync_w;
   logic [WIDTH-1:0]    stable_w;

   logic [31:0]         readdata_q, readdata_d;
   logic [WIDTH-1:0]    rise_en_q, rise_en_d;
   logic [WIDTH-1:0]    fall_en_q, fall_en_d;
   logic [WIDTH-1:0]    irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0]    edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0]    stable_prev_q, stable_prev_d;
   logic [DB_CNT_W-1:0] period_q, period_d;

   logic                wr_en;
   logic                period_wr;
   logic [WIDTH-1:0]    wdata_w;
   logic [WIDTH-1:0]    edge_clr;
   logic [WIDTH-1:0]    edge_set;

   // Read strobe and upper write bits carry no function; fold them into a sink.
   logic unused_bus;
   assign unused_bus = &{1'b0, read_n, writedata};

   assign wr_en     = chipselect & ~write_n;
   assign wdata_w   = writedata[WIDTH-1:0];
   assign period_wr = wr_en && (address == ADDR_PERIOD);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      pio_debounce_ch #(.DB_CNT_W(DB_CNT_W)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .in_raw   (in_port[i]),
         .period   (period_q),
         .cnt_clr  (period_wr),
         .sync_o   (sync_w[i]),
         .stable_o (stable_w[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_q    <= '0;
         rise_en_q     <= WIDTH'(RISE_RESET);
         fall_en_q     <= WIDTH'(FALL_RESET);
         irq_mask_q    <= '0;
         edge_cap_q    <= '0;
         stable_prev_q <= '0;
         period_q      <= DB_CNT_W'(DB_RESET);
      end else begin
         readdata_q    <= readdata_d;
         rise_en_q     <= rise_en_d;
         fall_en_q     <= fall_en_d;
         irq_mask_q    <= irq_mask_d;
         edge_cap_q    <= edge_cap_d;
         stable_prev_q <= stable_prev_d;
         period_q      <= period_d;
      end
   end

   // CSR updates, edge capture and read mux.
   always_comb begin
      rise_en_d     = rise_en_q;
      fall_en_d     = fall_en_q;
      irq_mask_d    = irq_mask_q;
      period_d      = period_q;
      stable_prev_d = stable_w;
      edge_clr      = '0;
      readdata_d    = '0;

      if (wr_en) begin
         case (address)
            ADDR_RISE_EN: rise_en_d  = wdata_w;
            ADDR_MASK:    irq_mask_d = wdata_w;
            ADDR_EDGE:    edge_clr   = wdata_w;
            ADDR_FALL_EN: fall_en_d  = wdata_w;
            ADDR_PERIOD:  period_d   = writedata[DB_CNT_W-1:0];
            default:      ;
         endcase
      end

      // A new edge in the same cycle as its clear keeps the bit set.
      edge_set   = ((stable_w & ~stable_prev_q) & rise_en_q) |
                   ((~stable_w & stable_prev_q) & fall_en_q);
      edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;

      case (address)
         ADDR_DATA:    readdata_d = 32'(stable_w);
         ADDR_RISE_EN: readdata_d = 32'(rise_en_q);
         ADDR_MASK:    readdata_d = 32'(irq_mask_q);
         ADDR_EDGE:    readdata_d = 32'(edge_cap_q);
         ADDR_FALL_EN: readdata_d = 32'(fall_en_q);
         ADDR_PERIOD:  readdata_d = 32'(period_q);
         ADDR_RAW:     readdata_d = 32'(sync_w);
         default:      readdata_d = '0;
      endcase
   end

   assign readdata = readdata_q;
   assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
